// File: rtl/vrf_read_pipe_pkg.sv
// vrf_read_pipe_pkg: shared widths, tag/request structs and credit sizing for vrf_read_pipe_mc.
package vrf_read_pipe_pkg;
    localparam int VS_W = 5;
    localparam int OFFSET_W = 6;
    localparam int IDX_W = 3;
    localparam int SRC_W = 2;
    localparam int QUEUE_DEPTH_DEF = 4;
    localparam int CREDIT_W = $clog2(QUEUE_DEPTH_DEF + 1);
    typedef struct packed {
        logic valid;
        logic [SRC_W-1:0] ch;
    } tag_t;
    typedef struct packed {
        logic [VS_W-1:0] vs;
        logic [OFFSET_W-1:0] offset;
        logic [IDX_W-1:0] idx;
    } req_t;
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/vrf_read_pipe_mc_if.sv
// vrf_read_pipe_mc_if: request, VRF port and result signals of vrf_read_pipe_mc.
interface vrf_read_pipe_mc_if #(parameter int NUM_CH = 2, parameter int DATA_W = 32);
    import vrf_read_pipe_pkg::*;
    logic [NUM_CH-1:0] enq_valid;
    logic [NUM_CH-1:0] enq_ready;
    logic [NUM_CH*VS_W-1:0] enq_vs;
    logic [NUM_CH*OFFSET_W-1:0] enq_offset;
    logic [NUM_CH*IDX_W-1:0] enq_instructionIndex;
    logic vrfReadRequest_ready;
    logic vrfReadRequest_valid;
    logic [VS_W-1:0] vrfReadRequest_bits_vs;
    logic [OFFSET_W-1:0] vrfReadRequest_bits_offset;
    logic [SRC_W-1:0] vrfReadRequest_bits_readSource;
    logic [IDX_W-1:0] vrfReadRequest_bits_instructionIndex;
    logic [DATA_W-1:0] vrfReadResult;
    logic [NUM_CH-1:0] deq_valid;
    logic [NUM_CH-1:0] deq_ready;
    logic [NUM_CH*DATA_W-1:0] deq_bits;
    modport slave (
        input enq_valid, enq_vs, enq_offset, enq_instructionIndex, vrfReadRequest_ready,
              vrfReadResult, deq_ready,
        output enq_ready, vrfReadRequest_valid, vrfReadRequest_bits_vs, vrfReadRequest_bits_offset,
               vrfReadRequest_bits_readSource, vrfReadRequest_bits_instructionIndex, deq_valid, deq_bits
    );
    modport master (
        output enq_valid, enq_vs, enq_offset, enq_instructionIndex, vrfReadRequest_ready,
               vrfReadResult, deq_ready,
        input enq_ready, vrfReadRequest_valid, vrfReadRequest_bits_vs, vrfReadRequest_bits_offset,
              vrfReadRequest_bits_readSource, vrfReadRequest_bits_instructionIndex, deq_valid, deq_bits
    );
endinterface

// File: rtl/vrf_read_pipe_fifo.sv
// vrf_read_pipe_fifo: show-ahead per-channel result FIFO, no write-to-read bypass.
// Define VRF_READ_PIPE_MC_ASSERT_EN to check for pushes into a full FIFO.
module vrf_read_pipe_fifo #(
    parameter int DATA_W = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic [DATA_W-1:0] din,
    input  logic pop,
    output logic valid,
    output logic [DATA_W-1:0] dout
);
    localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    logic [DATA_W-1:0] mem [QUEUE_DEPTH];
    logic [PW-1:0] wr, rd;
    logic [CW-1:0] cnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr <= '0;
            rd <= '0;
            cnt <= '0;
        end else begin
            if (push) wr <= (wr == PW'(QUEUE_DEPTH - 1)) ? '0 : wr + 1'b1;
            if (pop) rd <= (rd == PW'(QUEUE_DEPTH - 1)) ? '0 : rd + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clock) begin
        if (push) mem[wr] <= din;
    end
    assign valid = cnt != '0;
    assign dout = mem[rd];
`ifdef VRF_READ_PIPE_MC_ASSERT_EN
    always @(posedge clock) begin
        if (!reset) assert (!(push && cnt == CW'(QUEUE_DEPTH))) else $error("fifo push while full");
    end
`endif
endmodule

// File: rtl/vrf_read_pipe_mc.sv
// vrf_read_pipe_mc: round-robin shared VRF read port with tag-steered, credit-guarded result FIFOs.
// Define VRF_READ_PIPE_MC_ASSERT_EN for credit, one-hot and upstream-stability checks.
module vrf_read_pipe_mc
    import vrf_read_pipe_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int READ_LATENCY = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input logic clock,
    input logic reset,
    vrf_read_pipe_mc_if.slave io
);
    localparam int CW = credit_w(QUEUE_DEPTH);
    logic [CW-1:0] credit [NUM_CH];
    logic [NUM_CH-1:0] eligible, push, pop, take;
    logic [SRC_W-1:0] ptr, grant;
    logic fire;
    int best;
    tag_t tags [READ_LATENCY];
    req_t req [NUM_CH];
    req_t sel;
    // Rotating priority: smallest distance from ptr wins among eligible channels.
    always_comb begin
        eligible = '0;
        grant = '0;
        best = NUM_CH;
        sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            eligible[c] = io.enq_valid[c] & (credit[c] != '0);
            req[c] = '{vs: io.enq_vs[c*VS_W +: VS_W], offset: io.enq_offset[c*OFFSET_W +: OFFSET_W],
                       idx: io.enq_instructionIndex[c*IDX_W +: IDX_W]};
            if (eligible[c] && ((c >= int'(ptr)) ? c - int'(ptr) : c + NUM_CH - int'(ptr)) < best) begin
                best = (c >= int'(ptr)) ? c - int'(ptr) : c + NUM_CH - int'(ptr);
                grant = SRC_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) sel = (grant == SRC_W'(c)) ? req[c] : sel;
    end
    assign io.vrfReadRequest_valid = |eligible;
    assign fire = io.vrfReadRequest_valid & io.vrfReadRequest_ready;
    assign io.vrfReadRequest_bits_vs = sel.vs;
    assign io.vrfReadRequest_bits_offset = sel.offset;
    assign io.vrfReadRequest_bits_instructionIndex = sel.idx;
    assign io.vrfReadRequest_bits_readSource = grant;
    always_comb begin
        take = '0;
        push = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            take[c] = fire & (grant == SRC_W'(c));
            push[c] = tags[READ_LATENCY-1].valid & (tags[READ_LATENCY-1].ch == SRC_W'(c));
        end
    end
    assign io.enq_ready = take;
    assign pop = io.deq_valid & io.deq_ready;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tags[i] <= '0;
            for (int c = 0; c < NUM_CH; c++) credit[c] <= CW'(QUEUE_DEPTH);
        end else begin
            if (fire) ptr <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
            tags[0] <= '{valid: fire, ch: grant};
            for (int i = 1; i < READ_LATENCY; i++) tags[i] <= tags[i-1];
            for (int c = 0; c < NUM_CH; c++) credit[c] <= credit[c] + CW'(pop[c]) - CW'(take[c]);
        end
    end
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        vrf_read_pipe_fifo #(.DATA_W(DATA_W), .QUEUE_DEPTH(QUEUE_DEPTH)) u_fifo (
            .clock(clock),
            .reset(reset),
            .push(push[c]),
            .din(io.vrfReadResult),
            .pop(pop[c]),
            .valid(io.deq_valid[c]),
            .dout(io.deq_bits[c*DATA_W +: DATA_W])
        );
    end
`ifdef VRF_READ_PIPE_MC_ASSERT_EN
    logic stall_q;
    logic [SRC_W-1:0] grant_q;
    req_t sel_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_q <= 1'b0;
        else stall_q <= io.vrfReadRequest_valid & ~io.vrfReadRequest_ready;
        grant_q <= grant;
        sel_q <= sel;
    end
    always @(posedge clock) begin
        if (!reset) begin
            assert ($onehot0(io.enq_ready)) else $error("multiple enq_ready");
            for (int c = 0; c < NUM_CH; c++) begin
                assert (!(credit[c] == CW'(QUEUE_DEPTH) && pop[c] && !take[c])) else $error("credit overflow ch%0d", c);
                assert (!(credit[c] == '0 && take[c])) else $error("credit underflow ch%0d", c);
            end
            if (stall_q) assert (io.vrfReadRequest_valid && grant == grant_q && sel == sel_q)
                else $error("granted request changed while stalled");
        end
    end
`endif
endmodule

// File: doc/vrf_read_pipe_mc.md
Name: vrf_read_pipe_mc

Overview:
Multi-channel, parametrised VRF read pipe. NUM_CH independent requesters share one VRF read port through a round-robin arbiter. Read data returns after a fixed READ_LATENCY and is steered by a tag pipeline into a per-channel result FIFO. Per-channel credits guarantee that no issued read can overflow its FIFO, so issue no longer depends combinationally on the dequeue side. Sits between lane execution/LSU read stages and the VRF bank read port.

Parameters:
NUM_CH, 2, number of requesting channels (1..8)
DATA_W, 32, VRF read data width
VS_W, 5, vector register index width
OFFSET_W, 6, element-group offset width
IDX_W, 3, instruction index width
SRC_W, 2, readSource width; must satisfy 2**SRC_W >= NUM_CH
READ_LATENCY, 2, cycles from VRF request fire to valid vrfReadResult (1..4)
QUEUE_DEPTH, 4, entries per channel result FIFO (>= 1)

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
enq_valid  in  NUM_CH  per-channel read request valid
enq_ready  out  NUM_CH  per-channel request accepted
enq_vs  in  NUM_CH*VS_W  packed per-channel vs (channel c at [c*VS_W +: VS_W])
enq_offset  in  NUM_CH*OFFSET_W  packed per-channel offset
enq_instructionIndex  in  NUM_CH*IDX_W  packed per-channel instruction index
vrfReadRequest_ready  in  1  VRF port accepts request
vrfReadRequest_valid  out  1  request to VRF
vrfReadRequest_bits_vs  out  VS_W  granted vs
vrfReadRequest_bits_offset  out  OFFSET_W  granted offset
vrfReadRequest_bits_readSource  out  SRC_W  granted channel id
vrfReadRequest_bits_instructionIndex  out  IDX_W  granted instruction index
vrfReadResult  in  DATA_W  VRF data, valid READ_LATENCY cycles after request fire
deq_valid  out  NUM_CH  per-channel result available
deq_ready  in  NUM_CH  per-channel result consumer ready
deq_bits  out  NUM_CH*DATA_W  packed per-channel result data

Behaviour:
- Reset state: credit[c]=QUEUE_DEPTH, rr pointer=0, tag pipe valids=0, all FIFOs empty; deq_valid=0. enq_ready/vrfReadRequest_valid are combinational and may be 1 immediately after reset release.
- eligible[c] = enq_valid[c] & (credit[c] != 0); credit is the registered value, no same-cycle bypass.
- Arbiter: grant = first eligible channel at or after pointer, wrapping. vrfReadRequest_valid = |eligible; bits muxed from grant; readSource = grant zero-extended.
- enq_ready[c] = (grant==c) & eligible[c] & vrfReadRequest_ready. At most one bit set.
- Fire = vrfReadRequest_valid & vrfReadRequest_ready. On fire, pointer <= grant+1 mod NUM_CH; else pointer holds.
- Tag pipe: READ_LATENCY stages of {valid, channel}. Stage0 loaded with {fire, grant}. When last stage is valid, vrfReadResult is pushed into FIFO[channel] that cycle.
- Credit: decrement on fire for granted channel; increment on deq fire (deq_valid & deq_ready). Both in the same cycle: unchanged. Invariant: credit + in-flight + FIFO occupancy == QUEUE_DEPTH; push never sees a full FIFO.
- FIFO: show-ahead; deq_valid = not empty; pop and push in the same cycle are both honoured (occupancy unchanged). Push into an empty FIFO becomes visible the next cycle (no write-to-read bypass).
- Latency: request fire at cycle T, deq_valid at T+READ_LATENCY+1.
- Reset mid-operation: in-flight tags and FIFO contents are discarded; data returned after reset is ignored.

Optional Feature:
VRF_READ_PIPE_MC_ASSERT_EN: when defined, adds simulation assertions: push into a full FIFO, credit overflow/underflow, more than one enq_ready set, and granted-request bits changing while valid & !ready (upstream stability). When undefined, no extra logic; behaviour identical.

Decomposition:
- Package vrf_read_pipe_pkg: tag struct {valid, ch[SRC_W]}, the request-bits struct, and a clog2-based credit-width constant.
- One sub-module, vrf_read_pipe_fifo (DATA_W, QUEUE_DEPTH, show-ahead, async active-high reset), instantiated NUM_CH times.

Test Plan:
- Single channel, READ_LATENCY=2: ch0 request vs=3, off=5 fires at cycle 10; vrfReadResult=0xDEADBEEF at cycle 12 -> deq_valid[0]=1 at cycle 13 with deq_bits=0xDEADBEEF; credit 4->3->3, back to 4 after pop.
- Both channels valid continuously, vrfReadRequest_ready=1 -> grants alternate 0,1,0,1; readSource matches the grant.
- ch0 deq_ready=0, QUEUE_DEPTH=4 -> exactly 4 ch0 fires, then enq_ready[0]=0 while ch1 keeps issuing; one ch0 pop restores exactly one issue.
- vrfReadRequest_ready=0 for 3 cycles with ch1 valid -> grant and bits held stable, no tag issued, pointer unchanged.
- Credit==1: issue and pop on the same channel in the same cycle -> credit stays 1; FIFO push and pop in the same cycle keep occupancy.
- Assert reset with 2 reads in flight -> deq_valid=0 and credits=QUEUE_DEPTH; stale vrfReadResult is never pushed.
